// File: rtl/sensor_frame_pkg.sv
// Shared types and constants for the sensor frame assembler.
// State encoding, default field widths, frame_data field offsets and a popcount helper.
package sensor_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_e;

    localparam int DEF_ID_W   = 17;
    localparam int DEF_POLY_W = 17;
    localparam int DEF_TS_W   = 24;

    // frame_data = {poly_err, poly, id[N_CH-1] .. id[0]}
    localparam int FD_IDS_LSB = 0;

    function automatic int fd_poly_lsb(input int n_ch, input int id_w);
        return n_ch * id_w;
    endfunction

    function automatic int fd_err_bit(input int n_ch, input int id_w, input int poly_w);
        return n_ch * id_w + poly_w;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/sensor_frame_assembler_slot.sv
// One receiver channel slot: holds the captured pulse id and its filled flag,
// and flags a polynomial tag that disagrees with the frame reference.
module channel_slot #(
    parameter int ID_W   = 17,
    parameter int POLY_W = 17
) (
    input  logic              clk_96MHz,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              load,
    input  logic [ID_W-1:0]   id_in,
    input  logic [POLY_W-1:0] poly_in,
    input  logic [POLY_W-1:0] ref_poly,
    output logic [ID_W-1:0]   id_q,
    output logic              filled,
    output logic              poly_mismatch
);

    logic [ID_W-1:0] id_r;
    logic            filled_r;

    // Id and filled flag: cleared when the frame is consumed, loaded on capture.
    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            id_r     <= '0;
            filled_r <= 1'b0;
        end else if (clear) begin
            id_r     <= '0;
            filled_r <= 1'b0;
        end else if (load) begin
            id_r     <= id_in;
            filled_r <= 1'b1;
        end
    end

    assign id_q          = id_r;
    assign filled        = filled_r;
    assign poly_mismatch = (poly_in != ref_poly);

endmodule

// File: rtl/sensor_frame_assembler.sv
// Collects per-channel pulse ids into one frame within a bounded window and holds it for the consumer.
// Optional feature macro: SENSOR_FRAME_TS_EN (latch sys_ts when a frame opens; otherwise frame_ts is 0).
module sensor_frame_assembler
    import sensor_frame_pkg::*;
#(
    parameter int N_CH         = 3,
    parameter int ID_W         = DEF_ID_W,
    parameter int POLY_W       = DEF_POLY_W,
    parameter int TS_W         = DEF_TS_W,
    parameter int WINDOW_TICKS = 100
) (
    input  logic                         clk_96MHz,
    input  logic                         reset_n,
    input  logic [N_CH-1:0]              ch_valid,
    input  logic [N_CH*ID_W-1:0]         ch_id,
    input  logic [N_CH*POLY_W-1:0]       ch_poly,
    input  logic [TS_W-1:0]              sys_ts,
    input  logic                         frame_ready,
    output logic                         frame_valid,
    output logic [POLY_W+N_CH*ID_W:0]    frame_data,
    output logic [N_CH-1:0]              frame_mask,
    output logic [TS_W-1:0]              frame_ts,
    output logic [7:0]                   drop_count,
    output logic                         window_open
);

    localparam int CNT_W    = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
    localparam int POLY_LSB = fd_poly_lsb(N_CH, ID_W);
    localparam int ERR_BIT  = fd_err_bit(N_CH, ID_W, POLY_W);

    state_e                 state_r, state_nxt_s;
    logic [N_CH-1:0]        filled_s, load_s, dup_s, mismatch_s, mask_nxt_s;
    logic [N_CH*ID_W-1:0]   ids_s;
    logic [POLY_W-1:0]      poly_r, first_poly_s, ref_poly_s;
    logic                   poly_err_r, frame_valid_r, window_open_r;
    logic [CNT_W-1:0]       win_cnt_r;
    logic [7:0]             drop_r, drop_nxt_s;
    logic [7:0]             dup8_s;
    logic [3:0]             drop_inc_s;
    logic [8:0]             drop_sum_s;
    logic                   open_s, handshake_s, timeout_s, new_err_s;

    // Tag of the lowest-index strobing channel becomes the frame reference.
    always_comb begin
        first_poly_s = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            first_poly_s = ch_valid[k] ? ch_poly[k*POLY_W +: POLY_W] : first_poly_s;
        end
    end

    // Capture/drop decisions and next state.
    always_comb begin
        open_s      = (state_r == ST_IDLE) && (|ch_valid);
        handshake_s = (state_r == ST_EMIT) && frame_valid_r && frame_ready;
        timeout_s   = (state_r == ST_COLLECT) && (win_cnt_r == CNT_W'(WINDOW_TICKS - 1));
        ref_poly_s  = (state_r == ST_IDLE) ? first_poly_s : poly_r;
        load_s      = '0;
        dup_s       = '0;
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                load_s = ch_valid;
            end
            ST_COLLECT: begin
                load_s = ch_valid & ~filled_s;
                dup_s  = ch_valid & filled_s;
            end
            ST_EMIT: begin
                load_s = '0;
            end
            default: begin
                load_s = '0;
            end
        endcase
        mask_nxt_s = filled_s | load_s;
        new_err_s  = |(load_s & mismatch_s);
        case (state_r)
            ST_IDLE: begin
                if (open_s) begin
                    state_nxt_s = (mask_nxt_s == {N_CH{1'b1}}) ? ST_EMIT : ST_COLLECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if ((mask_nxt_s == {N_CH{1'b1}}) || timeout_s) begin
                    state_nxt_s = ST_EMIT;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_EMIT: begin
                if (handshake_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Drops: every duplicate strobe while collecting, one per cycle while holding.
    always_comb begin
        dup8_s             = '0;
        dup8_s[N_CH-1:0]   = dup_s;
        case (state_r)
            ST_COLLECT: drop_inc_s = popcount8(dup8_s);
            ST_EMIT:    drop_inc_s = (|ch_valid) ? 4'd1 : 4'd0;
            default:    drop_inc_s = 4'd0;
        endcase
        drop_sum_s = {1'b0, drop_r} + {5'd0, drop_inc_s};
        drop_nxt_s = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
    end

    // State, status flags and drop counter.
    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            frame_valid_r <= 1'b0;
            window_open_r <= 1'b0;
            drop_r        <= 8'd0;
        end else begin
            state_r       <= state_nxt_s;
            frame_valid_r <= (state_nxt_s == ST_EMIT);
            window_open_r <= (state_nxt_s == ST_COLLECT);
            drop_r        <= drop_nxt_s;
        end
    end

    // Window counter, reference tag and sticky tag-mismatch flag.
    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt_r  <= '0;
            poly_r     <= '0;
            poly_err_r <= 1'b0;
        end else if (open_s) begin
            win_cnt_r  <= '0;
            poly_r     <= first_poly_s;
            poly_err_r <= new_err_s;
        end else if (state_r == ST_COLLECT) begin
            win_cnt_r  <= win_cnt_r + CNT_W'(1);
            poly_err_r <= poly_err_r | new_err_s;
        end else if (handshake_s) begin
            win_cnt_r  <= '0;
            poly_r     <= '0;
            poly_err_r <= 1'b0;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_slot
        channel_slot #(
            .ID_W   (ID_W),
            .POLY_W (POLY_W)
        ) u_slot (
            .clk_96MHz     (clk_96MHz),
            .reset_n       (reset_n),
            .clear         (handshake_s),
            .load          (load_s[g]),
            .id_in         (ch_id[g*ID_W +: ID_W]),
            .poly_in       (ch_poly[g*POLY_W +: POLY_W]),
            .ref_poly      (ref_poly_s),
            .id_q          (ids_s[g*ID_W +: ID_W]),
            .filled        (filled_s[g]),
            .poly_mismatch (mismatch_s[g])
        );
    end

`ifdef SENSOR_FRAME_TS_EN
    logic [TS_W-1:0] ts_r;

    // Timestamp of the frame-opening edge.
    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            ts_r <= '0;
        end else if (open_s) begin
            ts_r <= sys_ts;
        end else if (handshake_s) begin
            ts_r <= '0;
        end
    end

    assign frame_ts = ts_r;
`else
    logic unused_ts_s;
    assign unused_ts_s = ^sys_ts;
    assign frame_ts    = '0;
`endif

    assign frame_data[ERR_BIT]                     = poly_err_r;
    assign frame_data[POLY_LSB +: POLY_W]          = poly_r;
    assign frame_data[FD_IDS_LSB +: N_CH*ID_W]     = ids_s;
    assign frame_mask                              = filled_s;
    assign frame_valid                             = frame_valid_r;
    assign window_open                             = window_open_r;
    assign drop_count                              = drop_r;

endmodule

// File: tb/tb_sensor_frame_assembler.sv
// Randomised and directed bench for sensor_frame_assembler against a frame-level reference model.
module tb_sensor_frame_assembler;

    localparam int N_CH   = 3;
    localparam int ID_W   = 17;
    localparam int POLY_W = 17;
    localparam int TS_W   = 24;
    localparam int WIN    = 100;
    localparam int FD_W   = 1 + POLY_W + N_CH*ID_W;

    logic                   clk_96MHz = 1'b0;
    logic                   reset_n;
    logic [N_CH-1:0]        ch_valid;
    logic [N_CH*ID_W-1:0]   ch_id;
    logic [N_CH*POLY_W-1:0] ch_poly;
    logic [TS_W-1:0]        sys_ts;
    logic                   frame_ready;
    logic                   frame_valid;
    logic [FD_W-1:0]        frame_data;
    logic [N_CH-1:0]        frame_mask;
    logic [TS_W-1:0]        frame_ts;
    logic [7:0]             drop_count;
    logic                   window_open;

    sensor_frame_assembler #(
        .N_CH(N_CH), .ID_W(ID_W), .POLY_W(POLY_W), .TS_W(TS_W), .WINDOW_TICKS(WIN)
    ) dut (
        .clk_96MHz   (clk_96MHz),
        .reset_n     (reset_n),
        .ch_valid    (ch_valid),
        .ch_id       (ch_id),
        .ch_poly     (ch_poly),
        .sys_ts      (sys_ts),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_mask  (frame_mask),
        .frame_ts    (frame_ts),
        .drop_count  (drop_count),
        .window_open (window_open)
    );

    always #5 clk_96MHz = ~clk_96MHz;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model: one frame at a time, either being gathered or held for the consumer.
    bit               m_gathering, m_held;
    int               m_age, m_drops;
    logic [N_CH-1:0]  m_mask;
    logic [ID_W-1:0]  m_id [N_CH];
    logic [POLY_W-1:0] m_poly;
    bit               m_err;
    logic [TS_W-1:0]  m_ts;

    function automatic logic [POLY_W-1:0] poly_of(input int k);
        return ch_poly[k*POLY_W +: POLY_W];
    endfunction

    function automatic void model_reset();
        m_gathering = 0; m_held = 0; m_age = 0; m_drops = 0;
        m_mask = '0; m_poly = '0; m_err = 0; m_ts = '0;
        for (int k = 0; k < N_CH; k++) m_id[k] = '0;
    endfunction

    function automatic void add_drop();
        if (m_drops < 255) m_drops++;
    endfunction

    function automatic void model_step();
        int first;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (m_held) begin
            if (ch_valid != '0) add_drop();
            if (frame_ready) begin
                m_held = 0; m_mask = '0; m_poly = '0; m_err = 0; m_ts = '0;
                for (int k = 0; k < N_CH; k++) m_id[k] = '0;
            end
        end else if (!m_gathering) begin
            if (ch_valid != '0) begin
                first = -1;
                for (int k = 0; k < N_CH; k++) if (ch_valid[k] && first < 0) first = k;
                m_poly = poly_of(first);
                m_ts   = sys_ts;
                m_age  = 0;
                for (int k = 0; k < N_CH; k++) begin
                    if (ch_valid[k]) begin
                        m_mask[k] = 1'b1;
                        m_id[k]   = ch_id[k*ID_W +: ID_W];
                        if (poly_of(k) != m_poly) m_err = 1;
                    end
                end
                if (&m_mask) m_held = 1;
                else m_gathering = 1;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (ch_valid[k]) begin
                    if (m_mask[k]) add_drop();
                    else begin
                        m_mask[k] = 1'b1;
                        m_id[k]   = ch_id[k*ID_W +: ID_W];
                        if (poly_of(k) != m_poly) m_err = 1;
                    end
                end
            end
            m_age++;
            if ((&m_mask) || m_age == WIN) begin
                m_gathering = 0;
                m_held      = 1;
            end
        end
    endfunction

    task automatic compare_all();
        logic [FD_W-1:0] fd;
        check_val("frame_valid", frame_valid, m_held);
        check_val("window_open", window_open, m_gathering);
        check_val("drop_count", drop_count, m_drops);
        if (m_held) begin
            fd = '0;
            fd[FD_W-1] = m_err;
            fd[N_CH*ID_W +: POLY_W] = m_poly;
            for (int k = 0; k < N_CH; k++) fd[k*ID_W +: ID_W] = m_id[k];
            check_val("frame_mask", frame_mask, m_mask);
            check_val("frame_data", frame_data, fd);
`ifdef SENSOR_FRAME_TS_EN
            check_val("frame_ts", frame_ts, m_ts);
`else
            check_val("frame_ts", frame_ts, '0);
`endif
        end
    endtask

    task automatic cycle();
        @(posedge clk_96MHz);
        model_step();
        #1;
        compare_all();
        sys_ts = sys_ts + 1'b1;
    endtask

    task automatic set_ch(input int k, input logic [ID_W-1:0] id, input logic [POLY_W-1:0] poly);
        ch_id[k*ID_W +: ID_W]       = id;
        ch_poly[k*POLY_W +: POLY_W] = poly;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_valid", frame_valid, 1'b0);
        check_val("rst_mask", frame_mask, '0);
        check_val("rst_data", frame_data, '0);
        check_val("rst_ts", frame_ts, '0);
        check_val("rst_drop", drop_count, 8'd0);
        check_val("rst_wopen", window_open, 1'b0);
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    logic [FD_W-1:0] expv_fd;
    int lat, wo;
`ifdef SENSOR_FRAME_TS_EN
    logic [TS_W-1:0] ts_open;
`endif

    initial begin
        reset_n     = 1'b0;
        ch_valid    = '0;
        ch_id       = '0;
        ch_poly     = '0;
        frame_ready = 1'b1;
        sys_ts      = TS_W'($urandom);
        #3;
        do_reset();

        // All three channels in one strobe.
        for (int k = 0; k < N_CH; k++) set_ch(k, ID_W'(5 + k), POLY_W'(26));
        ch_valid = 3'b111;
`ifdef SENSOR_FRAME_TS_EN
        ts_open = sys_ts;
`endif
        cycle();
        ch_valid = '0;
        expv_fd = {1'b0, 17'h1A, 17'd7, 17'd6, 17'd5};
        check_val("r029_valid", frame_valid, 1'b1);
        check_val("r029_mask", frame_mask, 3'b111);
        check_val("r029_data", frame_data, expv_fd);
`ifdef SENSOR_FRAME_TS_EN
        check_val("r029_ts", frame_ts, ts_open);
`else
        check_val("r029_ts", frame_ts, '0);
`endif
        cycle();
        check_val("r029_consumed", frame_valid, 1'b0);

        // Partial frame closed by the window.
        do_reset();
        frame_ready = 1'b0;
        set_ch(0, ID_W'(9), POLY_W'(26));
        ch_valid = 3'b001;
        cycle();
        ch_valid = '0;
        wo  = window_open ? 1 : 0;
        lat = 0;
        while (!frame_valid && lat < 300) begin
            cycle();
            lat++;
            if (window_open) wo++;
        end
        check_val("r030_latency", lat, WIN);
        check_val("r030_wopen_cycles", wo, WIN);
        check_val("r030_mask", frame_mask, 3'b001);
        check_val("r030_ids", frame_data[N_CH*ID_W-1:0], 51'd9);

        // Backpressure with strobes during hold.
        for (int i = 0; i < 20; i++) begin
            ch_valid = (i == 2 || i == 5 || i == 9 || i == 14) ? N_CH'($urandom_range(1, 7)) : '0;
            cycle();
        end
        ch_valid = '0;
        check_val("r031_hold", frame_valid, 1'b1);
        check_val("r031_drop", drop_count, 8'd4);
        frame_ready = 1'b1;
        cycle();
        check_val("r031_idle", frame_valid, 1'b0);

        // Duplicate strobe and tag mismatch.
        do_reset();
        frame_ready = 1'b0;
        set_ch(0, ID_W'(17), POLY_W'(26)); ch_valid = 3'b001; cycle();
        set_ch(1, ID_W'(34), POLY_W'(26)); ch_valid = 3'b010; cycle();
        set_ch(1, ID_W'(51), POLY_W'(26)); ch_valid = 3'b010; cycle();
        set_ch(2, ID_W'(68), POLY_W'(27)); ch_valid = 3'b100; cycle();
        ch_valid = '0;
        expv_fd = {1'b1, 17'h1A, 17'd68, 17'd34, 17'd17};
        check_val("r032_valid", frame_valid, 1'b1);
        check_val("r032_drop", drop_count, 8'd1);
        check_val("r032_data", frame_data, expv_fd);
        frame_ready = 1'b1;
        cycle();

        // Saturation, then reset in the middle of a window.
        do_reset();
        frame_ready = 1'b0;
        for (int k = 0; k < N_CH; k++) set_ch(k, ID_W'($urandom), POLY_W'(26));
        ch_valid = 3'b111;
        cycle();
        for (int i = 0; i < 300; i++) begin
            ch_valid = N_CH'($urandom_range(1, 7));
            cycle();
        end
        ch_valid = '0;
        check_val("r033_sat", drop_count, 8'd255);
        frame_ready = 1'b1;
        cycle();
        ch_valid = 3'b001;
        cycle();
        ch_valid = '0;
        for (int i = 0; i < 5; i++) cycle();
        check_val("r033_collecting", window_open, 1'b1);
        do_reset();
        for (int i = 0; i < 3 * WIN; i++) cycle();
        check_val("r033_no_frame", frame_valid, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            frame_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N_CH; k++)
                set_ch(k, ID_W'($urandom), ($urandom_range(0, 7) == 0) ? POLY_W'(27) : POLY_W'(26));
            ch_valid = ($urandom_range(0, 5) == 0) ? N_CH'($urandom_range(0, 7)) : '0;
            if (i == 1500) do_reset();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
